// File: rtl/flipflop_req_gen_if.sv
// flipflop_req_gen_if: raw request inputs and cleaned request outputs of flipflop_req_gen
//   set_raw_i / clr_raw_i     raw asynchronous set/clear requests (master drives)
//   set_pulse_o / clr_pulse_o one-cycle set/clear request pulses (slave drives)
//   set_lvl_o / clr_lvl_o     debounced levels of the raw inputs (slave drives)
interface flipflop_req_gen_if;
    logic set_raw_i;
    logic clr_raw_i;
    logic set_pulse_o;
    logic clr_pulse_o;
    logic set_lvl_o;
    logic clr_lvl_o;
    modport master (output set_raw_i, clr_raw_i, input set_pulse_o, clr_pulse_o, set_lvl_o, clr_lvl_o);
    modport slave (input set_raw_i, clr_raw_i, output set_pulse_o, clr_pulse_o, set_lvl_o, clr_lvl_o);
endinterface

// File: rtl/flipflop_req_gen.sv
// flipflop_req_gen: synchronizes, debounces and rise-detects two raw inputs into exclusive set/clear pulses
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side: set_raw_i/clr_raw_i in; set_pulse_o/clr_pulse_o/set_lvl_o/clr_lvl_o out
module flipflop_req_gen #(
    parameter int DB_CYCLES    = 4,
    parameter int CNT_W        = 3,
    parameter int PRIORITY_SET = 1
) (
    input  logic                clk,
    input  logic                rst,
    flipflop_req_gen_if.slave   bus
);
    // Channel index 0 is set, 1 is clear.
    logic [1:0]       raw, s1_q, s2_q, lvl_q, lvl_d, rise, go;
    logic [1:0]       pulse_q, pulse_d, pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       done;
    assign raw = {bus.clr_raw_i, bus.set_raw_i};
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            done[c]  = (s2_q[c] != lvl_q[c]) && (cnt_q[c] == CNT_W'(DB_CYCLES - 1));
            cnt_d[c] = (s2_q[c] == lvl_q[c] || done[c]) ? '0 : cnt_q[c] + CNT_W'(1);
            lvl_d[c] = done[c] ? s2_q[c] : lvl_q[c];
            rise[c]  = done[c] & s2_q[c];
        end
        // A deferred request competes like a fresh one; the loser of a collision is parked in pend.
        go         = rise | pend_q;
        pulse_d[0] = go[0] & ((PRIORITY_SET != 0) | ~go[1]);
        pulse_d[1] = go[1] & ((PRIORITY_SET == 0) | ~go[0]);
        pend_d     = go & ~pulse_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            lvl_q   <= '0;
            pulse_q <= '0;
            pend_q  <= '0;
            for (int c = 0; c < 2; c++) cnt_q[c] <= '0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            for (int c = 0; c < 2; c++) cnt_q[c] <= cnt_d[c];
        end
    end
    assign bus.set_pulse_o = pulse_q[0];
    assign bus.clr_pulse_o = pulse_q[1];
    assign bus.set_lvl_o   = lvl_q[0];
    assign bus.clr_lvl_o   = lvl_q[1];
endmodule

// File: tb/tb_flipflop_req_gen.sv
// tb_flipflop_req_gen: directed self-checking bench for flipflop_req_gen with both collision priorities
//   drives one pair of raw inputs into a PRIORITY_SET=1 instance (a) and a PRIORITY_SET=0 instance (b)
module tb_flipflop_req_gen;
    logic clk = 1'b0;
    logic rst;
    logic set_raw, clr_raw;
    int   checks = 0, failures = 0;
    int   set_cnt = 0, clr_cnt = 0;
    flipflop_req_gen_if bus_a ();
    flipflop_req_gen_if bus_b ();
    assign bus_a.set_raw_i = set_raw;
    assign bus_a.clr_raw_i = clr_raw;
    assign bus_b.set_raw_i = set_raw;
    assign bus_b.clr_raw_i = clr_raw;
    flipflop_req_gen #(.DB_CYCLES(4), .CNT_W(3), .PRIORITY_SET(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    flipflop_req_gen #(.DB_CYCLES(4), .CNT_W(3), .PRIORITY_SET(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    always #5 clk = ~clk;
    // {set_pulse, clr_pulse, set_lvl, clr_lvl}
    function automatic logic [3:0] outs_a();
        return {bus_a.set_pulse_o, bus_a.clr_pulse_o, bus_a.set_lvl_o, bus_a.clr_lvl_o};
    endfunction
    function automatic logic [1:0] pulses_b();
        return {bus_b.set_pulse_o, bus_b.clr_pulse_o};
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Advance one edge, then sample; the pulses of both instances must never overlap.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("excl_a", 32'(bus_a.set_pulse_o & bus_a.clr_pulse_o), 0);
            chk("excl_b", 32'(bus_b.set_pulse_o & bus_b.clr_pulse_o), 0);
            if (bus_a.set_pulse_o) set_cnt++;
            if (bus_a.clr_pulse_o) clr_cnt++;
        end
    endtask
    initial begin
        rst = 1'b1; set_raw = 1'b0; clr_raw = 1'b0;
        // T1: reset with toggling inputs
        for (int i = 0; i < 2; i++) begin
            set_raw = ~set_raw; clr_raw = set_raw;
            tick();
            chk("t1_rst", 32'(outs_a()), 0);
        end
        rst = 1'b0; set_raw = 1'b0; clr_raw = 1'b0;
        tick();
        chk("t1_release", 32'(outs_a()), 0);
        tick(8);
        chk("t1_idle", 32'(outs_a()), 0);
        // T2: single set press, pulse and level at E5
        set_raw = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("t2_wait", 32'(outs_a()), 0);
        end
        tick();
        chk("t2_e5", 32'(outs_a()), 32'b1010);
        tick();
        chk("t2_e6", 32'(outs_a()), 32'b0010);
        tick(4);
        chk("t2_hold", 32'(outs_a()), 32'b0010);
        set_raw = 1'b0;
        tick(8);
        chk("t2_fall", 32'(outs_a()), 0);
        // T3: short clear glitch rejected, clean press accepted
        set_cnt = 0; clr_cnt = 0;
        clr_raw = 1'b1;
        tick(3);
        clr_raw = 1'b0;
        tick(8);
        chk("t3_glitch_lvl", 32'(bus_a.clr_lvl_o), 0);
        chk("t3_glitch_cnt", clr_cnt, 0);
        clr_raw = 1'b1;
        tick(6);
        clr_raw = 1'b0;
        tick(10);
        chk("t3_press_cnt", clr_cnt, 1);
        chk("t3_set_cnt", set_cnt, 0);
        // T4: collision, a lets set win, b lets clear win
        set_raw = 1'b1; clr_raw = 1'b1;
        tick(5);
        chk("t4_pre_a", 32'(outs_a() & 4'b1100), 0);
        tick();
        chk("t4_e5_a", 32'({bus_a.set_pulse_o, bus_a.clr_pulse_o}), 32'b10);
        chk("t4_e5_b", 32'(pulses_b()), 32'b01);
        tick();
        chk("t4_e6_a", 32'({bus_a.set_pulse_o, bus_a.clr_pulse_o}), 32'b01);
        chk("t4_e6_b", 32'(pulses_b()), 32'b10);
        tick();
        chk("t4_e7_a", 32'({bus_a.set_pulse_o, bus_a.clr_pulse_o}), 0);
        chk("t4_e7_b", 32'(pulses_b()), 0);
        set_raw = 1'b0; clr_raw = 1'b0;
        tick(10);
        // T5: long hold, short release, second press
        set_cnt = 0;
        set_raw = 1'b1;
        tick(20);
        set_raw = 1'b0;
        tick(5);
        chk("t5_lvl_f4", 32'(bus_a.set_lvl_o), 1);
        tick();
        set_raw = 1'b1;
        tick();
        chk("t5_lvl_f6", 32'(bus_a.set_lvl_o), 0);
        tick(10);
        chk("t5_pulses", set_cnt, 2);
        set_raw = 1'b0;
        tick(10);
        // T6: reset mid-debounce while input stays high
        set_cnt = 0;
        set_raw = 1'b1;
        tick(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst", 32'(outs_a()), 0);
        chk("t6_none_before", set_cnt, 0);
        tick(5);
        chk("t6_e8", 32'(bus_a.set_pulse_o), 0);
        tick();
        chk("t6_e9", 32'(bus_a.set_pulse_o), 1);
        tick();
        chk("t6_e10", 32'(bus_a.set_pulse_o), 0);
        chk("t6_count", set_cnt, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
